// File: rtl/controle_contador_param_pkg.sv
// controle_contador_pkg: state encodings and sizing helper shared by the counter-control block.
package controle_contador_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_COUNT = 2'b10,
      ST_CLEAR = 2'b11
   } state_t;
   // A zero limit disables the timeout but the counter still needs one bit to exist.
   function automatic int tcnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction
endpackage

// File: rtl/controle_contador_param_updown.sv
// contador_updown_param: load/inc/dec/hold register exposing its next value for terminal compare.
module contador_updown_param #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic [WIDTH-1:0] load_value_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] next_o
);
   logic [WIDTH-1:0] count_q;
   always_comb next_o = load_i ? load_value_i :
                        inc_i  ? count_q + WIDTH'(1) :
                        dec_i  ? count_q - WIDTH'(1) : count_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) count_q <= '0;
      else     count_q <= next_o;
   assign count_o = count_q;
endmodule

// File: rtl/controle_contador_param.sv
// controle_contador_param: up/down counter control FSM with empty-buffer pause timeout and done/error flags.
// Build with CTRL_CONTADOR_AUTO_RELOAD_EN to make a terminal-count CLEAR reload and keep counting.
module controle_contador_param
   import controle_contador_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int PAUSE_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load_reg,
   input  logic             empty_buffer,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dir,
   output logic [WIDTH-1:0] count,
   output logic             load_c,
   output logic             enable_c,
   output logic             clear_reg,
   output logic             done,
   output logic             timeout_err,
   output logic [1:0]       state
);
   localparam int TW = tcnt_width(PAUSE_LIMIT);
   localparam logic [TW-1:0] LIMIT = TW'(PAUSE_LIMIT);
   state_t           state_q, state_d;
   logic             dir_q, dir_d, err_q, err_d, done_q, done_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             cnt_load, cnt_inc, cnt_dec;
   logic [WIDTH-1:0] cnt_val, cnt_next;
`ifdef CTRL_CONTADOR_AUTO_RELOAD_EN
   logic [WIDTH-1:0] start_q;
   always_ff @(posedge clk or posedge rst)
      if (rst)                                start_q <= '0;
      else if (enable && state_q == ST_LOAD)  start_q <= dir ? '0 : load_value;
`endif
   always_comb begin
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = dir ? '0 : load_value;
      if (enable) begin
         cnt_load = state_q == ST_LOAD;
         cnt_inc  = state_q == ST_COUNT && !load_reg && !empty_buffer && dir_q;
         cnt_dec  = state_q == ST_COUNT && !load_reg && !empty_buffer && !dir_q;
`ifdef CTRL_CONTADOR_AUTO_RELOAD_EN
         if (state_q == ST_CLEAR && !load_reg && done_q) begin
            cnt_load = 1'b1;
            cnt_val  = start_q;
         end
`endif
      end
   end
   contador_updown_param #(.WIDTH(WIDTH)) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .load_i       (cnt_load),
      .inc_i        (cnt_inc),
      .dec_i        (cnt_dec),
      .load_value_i (cnt_val),
      .count_o      (count),
      .next_o       (cnt_next)
   );
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      target_d = target_q;
      tcnt_d   = tcnt_q;
      err_d    = err_q;
      done_d   = done_q;
      if (enable)
         case (state_q)
            ST_IDLE: state_d = load_reg ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
               dir_d    = dir;
               target_d = dir ? load_value : '0;
               tcnt_d   = '0;
               err_d    = 1'b0;
               done_d   = load_value == '0;
               state_d  = (load_value == '0) ? ST_CLEAR : ST_COUNT;
            end
            ST_COUNT:
               if (load_reg) state_d = ST_LOAD;
               else if (empty_buffer) begin
                  tcnt_d = tcnt_q + TW'(1);
                  if (PAUSE_LIMIT != 0 && tcnt_d == LIMIT) begin
                     err_d   = 1'b1;
                     state_d = ST_CLEAR;
                  end
               end else begin
                  tcnt_d = '0;
                  // Compare the value being written so CLEAR lands right after target is reached.
                  if (cnt_next == target_q) begin
                     done_d  = 1'b1;
                     state_d = ST_CLEAR;
                  end
               end
            default: begin
               done_d = 1'b0;
`ifdef CTRL_CONTADOR_AUTO_RELOAD_EN
               state_d = load_reg ? ST_LOAD : done_q ? ST_COUNT : ST_IDLE;
`else
               state_d = load_reg ? ST_LOAD : ST_IDLE;
`endif
            end
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= 1'b0;
         target_q <= '0;
         tcnt_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         target_q <= target_d;
         tcnt_q   <= tcnt_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   assign state       = state_q;
   assign load_c      = enable && state_q == ST_LOAD;
   assign clear_reg   = enable && state_q == ST_CLEAR;
   assign enable_c    = enable && state_q == ST_COUNT && !empty_buffer;
   assign done        = enable && state_q == ST_CLEAR && done_q;
   assign timeout_err = err_q;
endmodule
